dmi_initiator: RTL and testbench
================================

# dmi_initiator

Requester end of the Debug Module Interface (DMI). It takes single read, write and nop commands from a host-side transport (JTAG DTM core, test harness, or a SoC bridge). For each command it issues one `dm::dmi_req_t` to the debug module, waits for the matching `dm::dmi_resp_t`, and returns the result to the host. It also tracks the sticky DMI error status (dmistat) with the same semantics as the DTM `dtmcs` register. At most one transaction is outstanding.

## Interface
Parameters:
- `TimeoutCycles`, default 1024: response timeout in cycles; used only when the timeout feature is compiled in; must be ≥ 2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `host_req_valid_i`  in  1  host command valid.
- `host_req_ready_o`  out  1  block can accept a command.
- `host_op_i`  in  2  `dm::dtm_op_e`.
- `host_addr_i`  in  7  DMI address.
- `host_data_i`  in  32  write data.
- `host_rsp_valid_o`  out  1  one-cycle result pulse; no backpressure.
- `host_rsp_data_o`  out  32  read data or last captured data.
- `host_rsp_err_o`  out  2  response code, one of DTM_SUCCESS/DTM_ERR/DTM_BUSY.
- `dmi_clear_i`  in  1  dmireset: clears sticky status.
- `dmi_hardreset_i`  in  1  dmihardreset: aborts the transaction and clears status.
- `dmistat_o`  out  2  sticky status.
- `dmi_req_o`  out  `dm::dmi_req_t`  request payload.
- `dmi_req_valid_o`  out  1.
- `dmi_req_ready_i`  in  1.
- `dmi_resp_i`  in  `dm::dmi_resp_t`.
- `dmi_resp_valid_i`  in  1.
- `dmi_resp_ready_o`  out  1.

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE. Reset state is IDLE.
- In IDLE, `host_req_ready_o`=1. A command is accepted on `valid&&ready`. Operand and address are registered at acceptance.
- Nop: no DMI traffic. Go to DONE; the result data is `last_data`; the error code is `dmistat`.
- Read/write when `dmistat`≠0: the command is dropped without DMI traffic. Go to DONE with error code `dmistat`, as the DTM requires.
- Read/write when `dmistat`=0: go to REQ. Hold `dmi_req_valid_o`=1 with a stable payload until `dmi_req_ready_i`, then go to WAIT_RSP.
- WAIT_RSP: `dmi_resp_ready_o`=1. On `dmi_resp_valid_i`, capture `resp.data` into `last_data` (both reads and writes) and go to DONE.
  - If the response code is DTM_ERR (2'h2) or DTM_BUSY (2'h3) and `dmistat`=0, set `dmistat` to that code.
  - Response code 2'h1 is treated as DTM_ERR.
- DONE: `host_rsp_valid_o`=1 for exactly one cycle, then go to IDLE.
- `dmi_resp_ready_o` is also 1 in IDLE. Stray responses arriving in IDLE are consumed and discarded, and nothing is updated.
- `dmistat` holds the first error code; later errors do not overwrite it.
- `dmi_clear_i` zeroes `dmistat` in any state. If it coincides with an error capture in the same cycle, the clear wins.
- `dmi_hardreset_i` forces IDLE from any state and zeroes `dmistat` and `last_data`. The host receives no response for the aborted command. It takes priority over every other event in that cycle.

## Timing
- Reset values: `host_req_ready_o`=1, `host_rsp_valid_o`=0, `host_rsp_data_o`=0, `host_rsp_err_o`=0, `dmistat_o`=0, `dmi_req_valid_o`=0, `dmi_req_o`=0, `dmi_resp_ready_o`=1.
- All outputs come from registers or from the state register only; there is no combinational path from any input to any output.
- Zero-wait read/write: accept in cycle 0, `dmi_req_valid_o` in cycle 1 with ready, response valid in cycle 2, `host_rsp_valid_o` in cycle 3. The next command can be accepted in cycle 4.
- Nop and dropped commands: accept in cycle 0, `host_rsp_valid_o` in cycle 1.
- `host_rsp_data_o` and `host_rsp_err_o` hold their value after the pulse until the next DONE.

## Configuration
- `DMI_INITIATOR_TIMEOUT_EN` defined:
  - A counter of width $clog2(TimeoutCycles+1) clears on entry to REQ and increments in REQ and WAIT_RSP.
  - When it reaches `TimeoutCycles`, drop `dmi_req_valid_o`, set `dmistat` to DTM_ERR if it is 0, and go to DONE with error code DTM_ERR and data `last_data`.
  - A response arriving in the same cycle as expiry wins over the timeout.
- Not defined: no counter; the block waits indefinitely.

## Structure
- `dm_pkg` additions: `localparam logic [1:0] DTM_ERR = 2'h2` and `DTM_BUSY = 2'h3`, alongside the existing `DTM_SUCCESS`.
- The `dmi_initiator_state_e` enum stays local to the module.
- Single module with no sub-modules. The timeout counter is inline under the macro guard.

## Test plan
- Read addr 0x11 (DMStatus); the DM returns data 0x00000C82, resp 0: host result is data 0x00000C82, error code 0, 3 cycles after acceptance; `dmistat`=0.
- Write 0x80000001 to 0x10 with `dmi_req_ready_i` held low for 5 cycles: payload stays stable throughout, then the op completes; a following nop returns the write's captured response data.
- Response code 3 (busy): `dmistat`=3. The next read produces no `dmi_req_valid_o` and returns error code 3 1 cycle after acceptance. Pulse `dmi_clear_i`; the next read is forwarded and completes with error code 0.
- Error code 2, then error code 3 on a later command: `dmistat` stays 2.
- `dmi_hardreset_i` asserted in WAIT_RSP, then a late response arrives 2 cycles later: no `host_rsp_valid_o`, the response is discarded, `host_req_ready_o`=1, `dmistat`=0.
- With `DMI_INITIATOR_TIMEOUT_EN` and `TimeoutCycles`=8: withhold the response → error code 2 exactly 8 cycles after entering REQ, `dmistat`=2; a response in the expiry cycle instead completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// Debug Module Interface types shared by the DMI requester and the debug module.
// Holds the DTM op encoding, the DMI request/response payloads and DTM response codes.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_initiator.sv
// DMI requester: one outstanding read/write/nop per host command, sticky dmistat tracking.
// Optional response timeout is compiled in with DMI_INITIATOR_TIMEOUT_EN.
module dmi_initiator
  import dm::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        host_req_valid_i,
  output logic        host_req_ready_o,
  input  dtm_op_e     host_op_i,
  input  logic [6:0]  host_addr_i,
  input  logic [31:0] host_data_i,
  output logic        host_rsp_valid_o,
  output logic [31:0] host_rsp_data_o,
  output logic [1:0]  host_rsp_err_o,
  input  logic        dmi_clear_i,
  input  logic        dmi_hardreset_i,
  output logic [1:0]  dmistat_o,
  output dmi_req_t    dmi_req_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  dmi_resp_t   dmi_resp_i,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} dmi_initiator_state_e;

  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("dmi_initiator: TimeoutCycles must be at least 2");
  end

  dmi_initiator_state_e state_q;
  dmi_req_t             req_q;
  logic [1:0]           dmistat_q;
  logic [31:0]          last_data_q;
  logic [31:0]          rsp_data_q;
  logic [1:0]           rsp_err_q;
  logic                 cmd_is_rw;
  logic [1:0]           resp_code;
  logic                 tmo_expired;

  assign cmd_is_rw = (host_op_i == DTM_READ) || (host_op_i == DTM_WRITE);
  // The reserved code 1 is folded into a plain error.
  assign resp_code = (dmi_resp_i.resp == 2'h1) ? DTM_ERR : dmi_resp_i.resp;

`ifdef DMI_INITIATOR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] tmo_cnt_q;
  // Expire in the cycle whose increment would reach TimeoutCycles.
  assign tmo_expired = (tmo_cnt_q >= CntW'(TimeoutCycles - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      dmistat_q   <= '0;
      last_data_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
`ifdef DMI_INITIATOR_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else if (dmi_hardreset_i) begin
      state_q     <= IDLE;
      dmistat_q   <= '0;
      last_data_q <= '0;
    end else begin
`ifdef DMI_INITIATOR_TIMEOUT_EN
      if (state_q == REQ || state_q == WAIT_RSP) tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
      case (state_q)
        IDLE: begin
          if (host_req_valid_i) begin
            req_q <= '{addr: host_addr_i, op: host_op_i, data: host_data_i};
            if (cmd_is_rw && dmistat_q == DTM_SUCCESS) begin
              state_q <= REQ;
`ifdef DMI_INITIATOR_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end else begin
              // Nops and commands dropped under a sticky error report the status.
              state_q    <= DONE;
              rsp_data_q <= last_data_q;
              rsp_err_q  <= dmistat_q;
            end
          end
        end
        REQ: begin
          if (dmi_req_ready_i) begin
            state_q <= WAIT_RSP;
          end else if (tmo_expired) begin
            state_q    <= DONE;
            rsp_data_q <= last_data_q;
            rsp_err_q  <= DTM_ERR;
            if (dmistat_q == DTM_SUCCESS) dmistat_q <= DTM_ERR;
          end
        end
        WAIT_RSP: begin
          if (dmi_resp_valid_i) begin
            state_q     <= DONE;
            last_data_q <= dmi_resp_i.data;
            rsp_data_q  <= dmi_resp_i.data;
            rsp_err_q   <= resp_code;
            if (dmistat_q == DTM_SUCCESS) dmistat_q <= resp_code;
          end else if (tmo_expired) begin
            state_q    <= DONE;
            rsp_data_q <= last_data_q;
            rsp_err_q  <= DTM_ERR;
            if (dmistat_q == DTM_SUCCESS) dmistat_q <= DTM_ERR;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Placed last so a clear beats an error capture in the same cycle.
      if (dmi_clear_i) dmistat_q <= '0;
    end
  end

  assign host_req_ready_o = (state_q == IDLE);
  assign host_rsp_valid_o = (state_q == DONE);
  assign host_rsp_data_o  = rsp_data_q;
  assign host_rsp_err_o   = rsp_err_q;
  assign dmistat_o        = dmistat_q;
  assign dmi_req_o        = req_q;
  assign dmi_req_valid_o  = (state_q == REQ);
  assign dmi_resp_ready_o = (state_q == IDLE) || (state_q == WAIT_RSP);

endmodule

// File: tb/tb_dmi_initiator.sv
// Bench for dmi_initiator: directed vector table, hand sequences, and random commands vs a model.
// Timeout scenarios are exercised only when DMI_INITIATOR_TIMEOUT_EN is defined.
module tb_dmi_initiator;
  import dm::*;

  localparam int T = 8;
`ifdef DMI_INITIATOR_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req_valid = 1'b0;
  logic        host_req_ready;
  dtm_op_e     host_op = DTM_NOP;
  logic [6:0]  host_addr = '0;
  logic [31:0] host_data = '0;
  logic        host_rsp_valid;
  logic [31:0] host_rsp_data;
  logic [1:0]  host_rsp_err;
  logic        dmi_clear = 1'b0;
  logic        dmi_hardreset = 1'b0;
  logic [1:0]  dmistat;
  dmi_req_t    dmi_req;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  dmi_resp_t   dmi_resp = '0;
  logic        dmi_resp_valid = 1'b0;
  logic        dmi_resp_ready;

  always #5 clk = ~clk;

  dmi_initiator #(.TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_valid_i(host_req_valid), .host_req_ready_o(host_req_ready),
    .host_op_i(host_op), .host_addr_i(host_addr), .host_data_i(host_data),
    .host_rsp_valid_o(host_rsp_valid), .host_rsp_data_o(host_rsp_data),
    .host_rsp_err_o(host_rsp_err), .dmi_clear_i(dmi_clear),
    .dmi_hardreset_i(dmi_hardreset), .dmistat_o(dmistat),
    .dmi_req_o(dmi_req), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
    .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          rd;
    int          rsd;
    bit          respond;
    logic [1:0]  code;
    logic [31:0] rdata;
    bit          clr_before;
    bit          clr_resp;
    int          e_lat;
    logic [31:0] e_data;
    logic [1:0]  e_err;
    bit          e_seen;
    logic [1:0]  e_stat;
  } vec_t;

  // Reference model: sticky status and last captured data.
  logic [1:0]  m_stat = '0;
  logic [31:0] m_last = '0;

  task automatic predict(input vec_t v, output int lat, output logic [31:0] d,
                         output logic [1:0] e, output bit seen, output logic [1:0] st);
    int cyc;
    logic [1:0] mapped;
    if (v.clr_before) m_stat = 2'd0;
    if (!((v.op == 1 || v.op == 2) && m_stat == 2'd0)) begin
      lat = 1; d = m_last; e = m_stat; seen = 1'b0;
    end else begin
      cyc  = v.rd + v.rsd + 2;
      seen = 1'b1;
      if (v.respond && (!TMO || cyc <= T)) begin
        mapped = (v.code == 2'd1) ? 2'd2 : v.code;
        lat = cyc + 1; m_last = v.rdata; d = v.rdata; e = mapped;
        if (m_stat == 2'd0) m_stat = mapped;
        if (v.clr_resp) m_stat = 2'd0;
      end else begin
        lat = T + 1; d = m_last; e = 2'd2;
        if (m_stat == 2'd0) m_stat = 2'd2;
      end
    end
    st = m_stat;
  endtask

  task automatic clear_pulse();
    @(negedge clk); dmi_clear = 1'b1;
    @(negedge clk); dmi_clear = 1'b0;
  endtask

  // Drives one host command and plays the debug module; returns what the host saw.
  task automatic run_cmd(input vec_t v, output int lat, output logic [31:0] gd,
                         output logic [1:0] ge, output bit seen, output bit stable,
                         output logic [1:0] st);
    int req_cyc, wc;
    bit hs, rdy;
    dmi_req_t exp_req;
    lat = -1; gd = '0; ge = '0; seen = 0; stable = 1; st = '0;
    rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_req_ready) begin rdy = 1; break; end
    end
    if (!rdy) return;
    exp_req = '{addr: v.addr, op: dtm_op_e'(v.op[1:0]), data: v.data};
    host_req_valid = 1'b1; host_op = dtm_op_e'(v.op[1:0]);
    host_addr = v.addr; host_data = v.data;
    @(posedge clk); #1 host_req_valid = 1'b0;
    req_cyc = 0; wc = 0; hs = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_clear = 1'b0;
      if (host_rsp_valid) begin
        lat = k; gd = host_rsp_data; ge = host_rsp_err; st = dmistat;
        break;
      end
      if (dmi_req_valid) begin
        seen = 1;
        if (dmi_req !== exp_req) stable = 0;
        req_cyc++;
        if (req_cyc > v.rd) begin dmi_req_ready = 1'b1; hs = 1; end
      end else if (hs && dmi_resp_ready) begin
        wc++;
        if (v.respond && wc > v.rsd) begin
          dmi_resp_valid = 1'b1; dmi_resp = '{data: v.rdata, resp: v.code};
          dmi_clear = v.clr_resp;
        end
      end
    end
  endtask

  task automatic exec_and_check(input string tag, input vec_t v, input bit use_table);
    int lat, e_lat;
    logic [31:0] gd, e_d;
    logic [1:0] ge, st, e_e, e_st;
    bit seen, stable, e_seen;
    predict(v, e_lat, e_d, e_e, e_seen, e_st);
    if (use_table) begin
      e_lat = v.e_lat; e_d = v.e_data; e_e = v.e_err; e_seen = v.e_seen; e_st = v.e_stat;
    end
    if (v.clr_before) clear_pulse();
    run_cmd(v, lat, gd, ge, seen, stable, st);
    $display("%s op=%0d addr=%h lat=%0d data=%h err=%0d dmistat=%0d", tag, v.op, v.addr, lat, gd, ge, st);
    chk({tag, " latency"}, 64'(lat), 64'(e_lat));
    chk({tag, " data"}, 64'(gd), 64'(e_d));
    chk({tag, " err"}, 64'(ge), 64'(e_e));
    chk({tag, " dmi_traffic"}, 64'(seen), 64'(e_seen));
    chk({tag, " payload_stable"}, 64'(stable), 64'd1);
    chk({tag, " dmistat"}, 64'(st), 64'(e_st));
  endtask

  vec_t vecs[10];
  vec_t v;
  bit bad;

  initial begin
    vecs[0] = '{1, 7'h11, 32'h0,          0, 0, 1, 2'd0, 32'h0000_0C82, 0, 0, 3, 32'h0000_0C82, 2'd0, 1, 2'd0};
    vecs[1] = '{2, 7'h10, 32'h8000_0001,  5, 0, 1, 2'd0, 32'h0000_ABCD, 0, 0, 8, 32'h0000_ABCD, 2'd0, 1, 2'd0};
    vecs[2] = '{0, 7'h00, 32'h0,          0, 0, 1, 2'd0, 32'h0,         0, 0, 1, 32'h0000_ABCD, 2'd0, 0, 2'd0};
    vecs[3] = '{1, 7'h04, 32'h0,          0, 0, 1, 2'd3, 32'h0000_1234, 0, 0, 3, 32'h0000_1234, 2'd3, 1, 2'd3};
    vecs[4] = '{1, 7'h05, 32'h0,          0, 0, 1, 2'd0, 32'h0,         0, 0, 1, 32'h0000_1234, 2'd3, 0, 2'd3};
    vecs[5] = '{1, 7'h06, 32'h0,          0, 0, 1, 2'd0, 32'h0000_0055, 1, 0, 3, 32'h0000_0055, 2'd0, 1, 2'd0};
    vecs[6] = '{2, 7'h07, 32'h0000_000F,  0, 0, 1, 2'd2, 32'h0000_0066, 0, 0, 3, 32'h0000_0066, 2'd2, 1, 2'd2};
    vecs[7] = '{1, 7'h08, 32'h0,          0, 0, 1, 2'd3, 32'h0,         0, 0, 1, 32'h0000_0066, 2'd2, 0, 2'd2};
    vecs[8] = '{1, 7'h09, 32'h0,          0, 2, 1, 2'd1, 32'h0000_0077, 1, 0, 5, 32'h0000_0077, 2'd2, 1, 2'd2};
    vecs[9] = '{1, 7'h0A, 32'h0,          0, 0, 1, 2'd2, 32'h0000_0099, 1, 1, 3, 32'h0000_0099, 2'd2, 1, 2'd0};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst host_req_ready", 64'(host_req_ready), 64'd1);
    chk("rst host_rsp_valid", 64'(host_rsp_valid), 64'd0);
    chk("rst host_rsp_data", 64'(host_rsp_data), 64'd0);
    chk("rst host_rsp_err", 64'(host_rsp_err), 64'd0);
    chk("rst dmistat", 64'(dmistat), 64'd0);
    chk("rst dmi_req_valid", 64'(dmi_req_valid), 64'd0);
    chk("rst dmi_req", 64'(dmi_req), 64'd0);
    chk("rst dmi_resp_ready", 64'(dmi_resp_ready), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) exec_and_check($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Hard reset while waiting for the response, then a late stray response.
    clear_pulse();
    bad = 0;
    @(negedge clk); host_req_valid = 1'b1; host_op = DTM_READ; host_addr = 7'h12;
    @(posedge clk); #1 host_req_valid = 1'b0;
    @(negedge clk); dmi_req_ready = 1'b1;
    @(negedge clk); dmi_req_ready = 1'b0; dmi_hardreset = 1'b1; bad |= host_rsp_valid;
    @(negedge clk); dmi_hardreset = 1'b0; bad |= host_rsp_valid;
    @(negedge clk); dmi_resp_valid = 1'b1; dmi_resp = '{data: 32'hDEAD_BEEF, resp: 2'd3}; bad |= host_rsp_valid;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dmi_resp_valid = 1'b0; bad |= host_rsp_valid;
    end
    $display("hardreset: rsp_seen=%0d ready=%0d dmistat=%0d", bad, host_req_ready, dmistat);
    chk("hardreset no_rsp", 64'(bad), 64'd0);
    chk("hardreset ready", 64'(host_req_ready), 64'd1);
    chk("hardreset dmistat", 64'(dmistat), 64'd0);
    m_stat = 2'd0; m_last = 32'h0;
    v = '{0, 7'h00, 32'h0, 0, 0, 1, 2'd0, 32'h0, 0, 0, 1, 32'h0, 2'd0, 0, 2'd0};
    exec_and_check("post_hardreset_nop", v, 1'b1);

`ifdef DMI_INITIATOR_TIMEOUT_EN
    v = '{1, 7'h13, 32'h0, 0, 0, 0, 2'd0, 32'h0, 0, 0, T + 1, 32'h0, 2'd2, 1, 2'd2};
    exec_and_check("timeout_no_rsp", v, 1'b1);
    v = '{1, 7'h14, 32'h0, 0, T - 2, 1, 2'd0, 32'h0000_0ABC, 1, 0, T + 1, 32'h0000_0ABC, 2'd0, 1, 2'd0};
    exec_and_check("timeout_rsp_at_expiry", v, 1'b1);
`endif

    // Random commands against the model.
    for (int n = 0; n < 40; n++) begin
      v.op = int'($urandom_range(0, 2));
      v.addr = 7'($urandom); v.data = $urandom;
      v.rd = int'($urandom_range(0, 3)); v.rsd = int'($urandom_range(0, 3));
      v.respond = 1'b1;
      v.code = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
      v.rdata = $urandom;
      v.clr_before = ($urandom_range(0, 3) == 0);
      v.clr_resp = 1'b0;
      exec_and_check($sformatf("rand%0d", n), v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
